// File: rtl/rand_range_gen_if.sv
// Request and divider handshake bundle for rand_range_gen.
// slave: the generator's view; master: the requester/divider environment.
interface rand_range_gen_if;
  logic        req;
  logic [31:0] range_val;
  logic        busy;
  logic        rnd_valid;
  logic [31:0] rnd;
  logic        err;
  logic        mod_gen;
  logic [31:0] mod_dividend;
  logic [31:0] mod_divisor;
  logic        mod_gen_end;
  logic [31:0] mod_res;

  modport slave (
    input  req,
    input  range_val,
    input  mod_gen_end,
    input  mod_res,
    output busy,
    output rnd_valid,
    output rnd,
    output err,
    output mod_gen,
    output mod_dividend,
    output mod_divisor
  );

  modport master (
    output req,
    output range_val,
    output mod_gen_end,
    output mod_res,
    input  busy,
    input  rnd_valid,
    input  rnd,
    input  err,
    input  mod_gen,
    input  mod_dividend,
    input  mod_divisor
  );
endinterface

// File: rtl/rand_range_gen.sv
// Bounded pseudo-random source: a Galois LFSR value reduced modulo range by an external divider.
// Optional WAIT watchdog enabled by defining RAND_RANGE_TIMEOUT_EN.
module rand_range_gen #(
  parameter logic [31:0] SEED    = 32'h0000_0001,
  parameter logic [31:0] TAPS    = 32'h8020_0003,
  parameter int unsigned TIMEOUT = 64
) (
  input logic             i_clk,
  input logic             i_rst,
  rand_range_gen_if.slave io_bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLaunch = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [31:0] SeedEff = (SEED == 32'd0) ? 32'd1 : SEED;

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("rand_range_gen: TIMEOUT must be nonzero");
  end

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [31:0] r_lfsr;
  logic [31:0] w_lfsr_next;
  logic [31:0] w_lfsr_step;
  logic [31:0] r_rnd;
  logic [31:0] w_rnd_next;
  logic [31:0] r_dividend;
  logic [31:0] w_dividend_next;
  logic [31:0] r_divisor;
  logic [31:0] w_divisor_next;
  logic        r_err;
  logic        w_err_next;
  logic        w_range_zero;

`ifdef RAND_RANGE_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic            w_expired;

  assign w_expired = (r_cnt == CntLast);
`endif

  assign w_range_zero = (io_bus.range_val == 32'd0);
  assign w_lfsr_step  = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

  always_comb begin
    w_state_next    = r_state;
    w_lfsr_next     = r_lfsr;
    w_rnd_next      = r_rnd;
    w_dividend_next = r_dividend;
    w_divisor_next  = r_divisor;
    w_err_next      = 1'b0;
`ifdef RAND_RANGE_TIMEOUT_EN
    w_cnt_next      = r_cnt;
`endif
    case (r_state)
      StIdle: begin
        if (io_bus.req) begin
          if (w_range_zero) begin
            w_err_next = 1'b1;
          end else begin
            w_lfsr_next     = w_lfsr_step;
            w_dividend_next = w_lfsr_step;
            w_divisor_next  = io_bus.range_val;
            w_state_next    = StLaunch;
          end
        end
      end
      StLaunch: begin
        w_state_next = StWait;
`ifdef RAND_RANGE_TIMEOUT_EN
        w_cnt_next   = '0;
`endif
      end
      StWait: begin
        // A completion in the final watchdog cycle still wins over the timeout.
        if (io_bus.mod_gen_end) begin
          w_rnd_next   = io_bus.mod_res;
          w_state_next = StDone;
        end
`ifdef RAND_RANGE_TIMEOUT_EN
        else if (w_expired) begin
          w_err_next   = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
`endif
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_lfsr     <= SeedEff;
      r_rnd      <= 32'd0;
      r_dividend <= 32'd0;
      r_divisor  <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_lfsr     <= w_lfsr_next;
      r_rnd      <= w_rnd_next;
      r_dividend <= w_dividend_next;
      r_divisor  <= w_divisor_next;
      r_err      <= w_err_next;
    end
  end

`ifdef RAND_RANGE_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end
`endif

  assign io_bus.busy         = (r_state != StIdle);
  assign io_bus.rnd_valid    = (r_state == StDone);
  assign io_bus.mod_gen      = (r_state == StLaunch);
  assign io_bus.err          = r_err;
  assign io_bus.rnd          = r_rnd;
  assign io_bus.mod_dividend = r_dividend;
  assign io_bus.mod_divisor  = r_divisor;

endmodule

// File: tb/tb_rand_range_gen.sv
// Self-checking bench for rand_range_gen: vector table plus hand-written corner sequences,
// with a behavioural remainder divider and an expectation queue checked at launch and result.
module tb_rand_range_gen;

  localparam logic [31:0] SeedP     = 32'h0000_0001;
  localparam logic [31:0] TapsP     = 32'h8020_0003;
  localparam int unsigned TimeoutP  = 8;
  localparam int          ModLat    = 4;  // divider answers 4 edges after sampling mod_gen
  localparam int          BusyCyc   = 7;
  localparam int          NumVec    = 7;

  typedef struct {
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] rnd;
  } exp_t;

  typedef struct {
    logic [31:0] rng;
    bit          err;
    logic [31:0] dividend;
    logic [31:0] rnd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gen_pulses = 0;
  int valid_pulses = 0;
  int err_pulses = 0;
  int busy_cycles = 0;
  int last_gen_cyc = 0;
  int gen_gap = 0;

  exp_t        sb[$];
  logic [31:0] m_lfsr = SeedP;

  logic        mod_stall = 1'b0;
  logic        m_end = 1'b0;
  logic        stray_end = 1'b0;
  logic [31:0] m_res = 32'd0;
  bit          m_busy = 1'b0;
  int          m_cnt = 0;

  rand_range_gen_if bus ();

  assign bus.mod_gen_end = m_end | stray_end;
  assign bus.mod_res     = m_res;

  rand_range_gen #(
    .SEED   (SeedP),
    .TAPS   (TapsP),
    .TIMEOUT(TimeoutP)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TapsP) : (s >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural divider; deliberately ignores rst so a late answer can follow a reset.
  always @(posedge clk) begin
    m_end <= 1'b0;
    if (bus.mod_gen && !mod_stall) begin
      m_busy <= 1'b1;
      m_cnt  <= ModLat;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_end  <= 1'b1;
        m_res  <= (bus.mod_divisor == 0) ? 32'd0 : bus.mod_dividend % bus.mod_divisor;
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.mod_gen) begin
        gen_gap      = cyc - last_gen_cyc;
        last_gen_cyc = cyc;
        gen_pulses++;
        check("launch_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("launch_dividend", bus.mod_dividend, sb[0].dividend);
          check("launch_divisor", bus.mod_divisor, sb[0].divisor);
        end
      end
      if (bus.rnd_valid) begin
        valid_pulses++;
        check("result_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("result_rnd", bus.rnd, e.rnd);
        end
      end
      if (bus.err) err_pulses++;
      if (bus.busy) busy_cycles++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_rnd_valid"}, 32'(bus.rnd_valid), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_mod_gen"}, 32'(bus.mod_gen), 32'd0);
    check({tag, "_rnd"}, bus.rnd, 32'd0);
    check({tag, "_dividend"}, bus.mod_dividend, 32'd0);
    check({tag, "_divisor"}, bus.mod_divisor, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_lfsr = SeedP;
  endtask

  // Drives one request for a single cycle; returns at the negedge of the launch cycle.
  task automatic issue(input logic [31:0] rng);
    @(negedge clk);
    bus.req       = 1'b1;
    bus.range_val = rng;
    if (rng != 32'd0) begin
      m_lfsr = lfsr_next(m_lfsr);
      sb.push_back('{dividend: m_lfsr, divisor: rng, rnd: m_lfsr % rng});
    end
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (bus.busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.busy), 32'd0);
    #1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got hang, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vt[NumVec];
    logic [31:0] tail_rng[4];
    logic [31:0] s;
    int g0, v0, e0, b0, n;
    logic [31:0] rnd0;

    vt[0] = '{rng: 32'd10,  err: 1'b0, dividend: 32'h8020_0003, rnd: 32'd3};
    vt[1] = '{rng: 32'd100, err: 1'b0, dividend: 32'hC030_0002, rnd: 32'd2};
    vt[2] = '{rng: 32'd0,   err: 1'b1, dividend: 32'hC030_0002, rnd: 32'd2};
    tail_rng = '{32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3};
    s = 32'hC030_0002;
    for (int i = 0; i < 4; i++) begin
      s = lfsr_next(s);
      vt[3 + i] = '{rng: tail_rng[i], err: 1'b0, dividend: s, rnd: s % tail_rng[i]};
    end

    bus.req       = 1'b0;
    bus.range_val = 32'd0;

    // Reset state, with a stray completion while in reset.
    repeat (2) @(negedge clk);
    stray_end = 1'b1;
    @(negedge clk);
    stray_end = 1'b0;
    check_reset_outputs("reset");
    rst = 1'b0;
    sb.delete();
    m_lfsr = SeedP;

    // Stray completion in IDLE must be ignored.
    v0 = valid_pulses;
    @(negedge clk);
    stray_end = 1'b1;
    @(negedge clk);
    stray_end = 1'b0;
    @(negedge clk);
    #1;
    check("stray_no_valid", 32'(valid_pulses - v0), 32'd0);
    check("stray_busy", 32'(bus.busy), 32'd0);
    check("stray_rnd", bus.rnd, 32'd0);

    for (int i = 0; i < NumVec; i++) begin
      g0 = gen_pulses;
      v0 = valid_pulses;
      e0 = err_pulses;
      b0 = busy_cycles;
      issue(vt[i].rng);
      wait_idle("row_idle", 40);
      @(negedge clk);
      #1;
      check("row_gen_pulses", 32'(gen_pulses - g0), vt[i].err ? 32'd0 : 32'd1);
      check("row_valid_pulses", 32'(valid_pulses - v0), vt[i].err ? 32'd0 : 32'd1);
      check("row_err_pulses", 32'(err_pulses - e0), vt[i].err ? 32'd1 : 32'd0);
      check("row_busy_cycles", 32'(busy_cycles - b0), vt[i].err ? 32'd0 : 32'(BusyCyc));
      check("row_dividend", bus.mod_dividend, vt[i].dividend);
      check("row_rnd", bus.rnd, vt[i].rnd);
    end

    // After reset, range=0 must not advance the LFSR.
    do_reset();
    e0 = err_pulses;
    issue(32'd0);
    issue(32'd10);
    wait_idle("zero_then_ten_idle", 40);
    check("zero_err_pulses", 32'(err_pulses - e0), 32'd1);
    check("zero_then_ten_dividend", bus.mod_dividend, 32'h8020_0003);
    check("zero_then_ten_rnd", bus.rnd, 32'd3);

    // req held high: re-accepted on the first IDLE cycle, spacing k+3 with k=5.
    g0 = gen_pulses;
    v0 = valid_pulses;
    @(negedge clk);
    bus.req       = 1'b1;
    bus.range_val = 32'd5;
    for (int j = 0; j < 2; j++) begin
      m_lfsr = lfsr_next(m_lfsr);
      sb.push_back('{dividend: m_lfsr, divisor: 32'd5, rnd: m_lfsr % 32'd5});
    end
    n = 0;
    while ((gen_pulses - g0) < 2 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    bus.req = 1'b0;
    check("held_two_launches", 32'(gen_pulses - g0), 32'd2);
    check("held_gap", 32'(gen_gap), 32'd8);
    wait_idle("held_idle", 40);
    @(negedge clk);
    #1;
    check("held_valid_pulses", 32'(valid_pulses - v0), 32'd2);
    check("held_sb_empty", 32'(sb.size()), 32'd0);

    // req during WAIT is ignored; rst during WAIT discards the late answer.
    do_reset();
    issue(32'd10);
    @(negedge clk);
    bus.req       = 1'b1;
    bus.range_val = 32'd3;
    @(negedge clk);
    bus.req = 1'b0;
    check("wait_req_divisor", bus.mod_divisor, 32'd10);
    check("wait_req_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    rst    = 1'b0;
    m_lfsr = SeedP;
    v0     = valid_pulses;
    repeat (6) @(negedge clk);
    #1;
    check("late_end_no_valid", 32'(valid_pulses - v0), 32'd0);
    check("late_end_rnd", bus.rnd, 32'd0);
    issue(32'd7);
    wait_idle("reseed_idle", 40);
    check("reseed_dividend", bus.mod_dividend, 32'h8020_0003);
    check("reseed_rnd", bus.rnd, 32'd6);

    // Stalled divider.
    mod_stall = 1'b1;
    e0   = err_pulses;
    v0   = valid_pulses;
    rnd0 = bus.rnd;
`ifdef RAND_RANGE_TIMEOUT_EN
    issue(32'd10);
    n = 0;
    while (!bus.err && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout_err_seen", 32'(bus.err), 32'd1);
    check("timeout_latency", 32'(n), 32'(TimeoutP + 1));
    check("timeout_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    #1;
    check("timeout_err_pulses", 32'(err_pulses - e0), 32'd1);
    check("timeout_no_valid", 32'(valid_pulses - v0), 32'd0);
    check("timeout_rnd_held", bus.rnd, rnd0);
    check("timeout_pending", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) void'(sb.pop_front());
    mod_stall = 1'b0;
    issue(32'd9);
    wait_idle("after_timeout_idle", 40);
    @(negedge clk);
    #1;
    check("after_timeout_rnd", bus.rnd, m_lfsr % 32'd9);
`else
    issue(32'd10);
    repeat (100) @(negedge clk);
    #1;
    check("stall_busy", 32'(bus.busy), 32'd1);
    check("stall_no_err", 32'(err_pulses - e0), 32'd0);
    check("stall_no_valid", 32'(valid_pulses - v0), 32'd0);
    mod_stall = 1'b0;
    do_reset();
    @(negedge clk);
    check("stall_reset_busy", 32'(bus.busy), 32'd0);
`endif

    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
